// File: rtl/vend_pkg.sv
// Shared encodings for the change-return hopper sequencer: state codes,
// coin select codes and the coin values behind them.
package vend_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CALC     = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_FAULT    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_CALC     = ST_CALC,
        S_CHECK    = ST_CHECK,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_WAIT_REL = ST_WAIT_REL,
        S_DONE     = ST_DONE,
        S_FAULT    = ST_FAULT
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_5    = 2'b10;
    localparam logic [1:0] COIN_10   = 2'b11;

    localparam logic [4:0] DENOM_1   = 5'd1;
    localparam logic [4:0] DENOM_5   = 5'd5;
    localparam logic [4:0] DENOM_10  = 5'd10;
    localparam logic [4:0] COUNT_MAX = 5'd31;

    function automatic logic [4:0] denom_of(input logic [1:0] sel);
        case (sel)
            COIN_10: denom_of = DENOM_10;
            COIN_5:  denom_of = DENOM_5;
            COIN_1:  denom_of = DENOM_1;
            default: denom_of = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/handshake_timer.sv
// Cycle counter used to bound each ack edge wait; parks at its terminal
// count so a stuck hopper keeps reporting the timeout instead of wrapping.
module handshake_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_r;
    logic             tc_s;

    // terminal-count decode
    always_comb begin
        tc_s = (count_r == TC_VAL);
    end

    // counter register: clear wins over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && !tc_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = tc_s;

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change-return sequencer: computes paid - price and issues it greedily as
// 10/5/1 coins, one four-phase req/ack handshake with the hopper per coin.
import vend_pkg::*;

module change_dispense_ctrl #(
    parameter int AMT_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] paid,
    input  logic [AMT_W-1:0] price,
    input  logic             clear,
    input  logic             coin_ack,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             short_pay,
    output logic             jam,
    output logic [AMT_W-1:0] remaining,
    output logic [4:0]       coin_count
);

    state_t           state_r, state_s;
    logic [AMT_W-1:0] paid_r, paid_s;
    logic [AMT_W-1:0] price_r, price_s;
    logic [AMT_W-1:0] remaining_r, remaining_s;
    logic [4:0]       coin_count_r, coin_count_s;
    logic             coin_req_r, coin_req_s;
    logic [1:0]       coin_sel_r, coin_sel_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             short_pay_r, short_pay_s;
    logic             jam_r, jam_s;
    logic             in_wait_s;
    logic             tmr_clr_s;
    logic             tmr_tc_s;

    handshake_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr_s),
        .en    (in_wait_s),
        .tc    (tmr_tc_s)
    );

    // next-state and next-output decode
    always_comb begin
        state_s      = state_r;
        paid_s       = paid_r;
        price_s      = price_r;
        remaining_s  = remaining_r;
        coin_count_s = coin_count_r;
        coin_req_s   = coin_req_r;
        coin_sel_s   = coin_sel_r;
        jam_s        = jam_r;
        done_s       = 1'b0;
        short_pay_s  = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    paid_s       = paid;
                    price_s      = price;
                    coin_count_s = 5'd0;
                    state_s      = S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (paid_r < price_r) begin
                    short_pay_s = 1'b1;
                    done_s      = 1'b1;
                    remaining_s = '0;
                    state_s     = S_IDLE;
                end else begin
                    remaining_s = paid_r - price_r;
                    state_s     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (remaining_r == '0) begin
                    state_s = S_DONE;
                end else begin
                    if (remaining_r >= AMT_W'(DENOM_10)) begin
                        coin_sel_s = COIN_10;
                    end else if (remaining_r >= AMT_W'(DENOM_5)) begin
                        coin_sel_s = COIN_5;
                    end else begin
                        coin_sel_s = COIN_1;
                    end
                    coin_req_s = 1'b1;
                    state_s    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // an ack arriving on the terminal-count cycle still counts
                if (coin_ack) begin
                    remaining_s  = remaining_r - AMT_W'(denom_of(coin_sel_r));
                    coin_count_s = (coin_count_r == COUNT_MAX) ? COUNT_MAX
                                                               : coin_count_r + 5'd1;
                    coin_req_s   = 1'b0;
                    state_s      = S_WAIT_REL;
                end else if (tmr_tc_s) begin
                    coin_req_s = 1'b0;
                    coin_sel_s = COIN_NONE;
                    jam_s      = 1'b1;
                    state_s    = S_FAULT;
                end else begin
                    state_s = S_WAIT_ACK;
                end
            end
            S_WAIT_REL: begin
                if (!coin_ack) begin
                    coin_sel_s = COIN_NONE;
                    state_s    = S_CHECK;
                end else if (tmr_tc_s) begin
                    coin_req_s = 1'b0;
                    coin_sel_s = COIN_NONE;
                    jam_s      = 1'b1;
                    state_s    = S_FAULT;
                end else begin
                    state_s = S_WAIT_REL;
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                state_s = S_IDLE;
            end
            S_FAULT: begin
                coin_req_s = 1'b0;
                coin_sel_s = COIN_NONE;
                if (clear) begin
                    jam_s   = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    jam_s   = 1'b1;
                    state_s = S_FAULT;
                end
            end
            default: begin
                coin_req_s = 1'b0;
                coin_sel_s = COIN_NONE;
                jam_s      = 1'b0;
                state_s    = S_IDLE;
            end
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // handshake timer control: restart on every state change
    always_comb begin
        in_wait_s = (state_r == S_WAIT_ACK) || (state_r == S_WAIT_REL);
        tmr_clr_s = (state_s != state_r) || !in_wait_s;
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            paid_r       <= '0;
            price_r      <= '0;
            remaining_r  <= '0;
            coin_count_r <= 5'd0;
            coin_req_r   <= 1'b0;
            coin_sel_r   <= COIN_NONE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            short_pay_r  <= 1'b0;
            jam_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            paid_r       <= paid_s;
            price_r      <= price_s;
            remaining_r  <= remaining_s;
            coin_count_r <= coin_count_s;
            coin_req_r   <= coin_req_s;
            coin_sel_r   <= coin_sel_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            short_pay_r  <= short_pay_s;
            jam_r        <= jam_s;
        end
    end

    assign coin_req   = coin_req_r;
    assign coin_sel   = coin_sel_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign short_pay  = short_pay_r;
    assign jam        = jam_r;
    assign remaining  = remaining_r;
    assign coin_count = coin_count_r;

endmodule
